mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 61 ++++++
 tb/tb_mem_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; holds the first-cycle SRAM read word across
// writeback stalls and extracts sign/zero-extended load data.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [75:0] es_to_ms_bus,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [4:0]  ms_fwd_dest,
  output logic [31:0] ms_fwd_res
);
  logic        ms_valid, hold, ms_ready_go, accept, capture;
  logic [31:0] hold_buf, rdata_eff, shifted, mem_res, final_res;
  logic [75:0] bus_r;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_b, ld_h, ld_w, ld_bu, ld_hu, res_from_mem, gr_we, is_w;
  logic [4:0]  dest;
  logic [31:0] exe_res, pc;
  assign {ld_b, ld_h, ld_w, ld_bu, ld_hu, res_from_mem, gr_we, dest, exe_res, pc} = bus_r;
  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept      = es_to_ms_valid && ms_allowin;
  assign capture     = ms_valid && res_from_mem && !hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      hold     <= 1'b0;
      hold_buf <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      hold <= accept ? 1'b0 : (capture ? 1'b1 : hold);
      if (capture) hold_buf <= data_sram_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) bus_r <= es_to_ms_bus;
  end
  // A load with no type bit set is treated as a full-word load.
  always_comb begin
    is_w      = ld_w || !(ld_b || ld_h || ld_bu || ld_hu);
    rdata_eff = hold ? hold_buf : data_sram_rdata;
    shifted   = rdata_eff >> {exe_res[1:0], 3'b000};
    ld_byte   = shifted[7:0];
    ld_half   = exe_res[1] ? rdata_eff[31:16] : rdata_eff[15:0];
    mem_res   = is_w  ? rdata_eff :
                ld_b  ? {{24{ld_byte[7]}}, ld_byte} :
                ld_bu ? {24'b0, ld_byte} :
                ld_h  ? {{16{ld_half[15]}}, ld_half} :
                ld_hu ? {16'b0, ld_half} : rdata_eff;
    final_res = res_from_mem ? mem_res : exe_res;
  end
  assign ms_to_ws_valid = ms_valid;
  assign ms_to_ws_bus   = {gr_we, dest, final_res, pc};
  assign ms_fwd_dest    = dest & {5{ms_valid & gr_we}};
  assign ms_fwd_res     = final_res;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_allowin = 1'b1;
  logic        ms_allowin;
  logic        es_to_ms_valid = 1'b0;
  logic [75:0] es_to_ms_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_res;
  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_res(ms_fwd_res)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] LD_B = 5'b10000, LD_H = 5'b01000, LD_W = 5'b00100,
                         LD_BU = 5'b00010, LD_HU = 5'b00001, LD_NONE = 5'b00000;

  function automatic logic [75:0] mk(input logic [4:0] ld, input logic rfm, input logic we,
                                     input logic [4:0] dst, input logic [31:0] res, input logic [31:0] pc);
    return {ld, rfm, we, dst, res, pc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [75:0] b);
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    @(posedge clk);
    #1;
    es_to_ms_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_fwd_dest", 32'(ms_fwd_dest), 32'd0);
    reset = 1'b0;

    issue(mk(LD_B, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h0000_0100));
    data_sram_rdata = 32'h80FF_1234; #1;
    chk("ld_b_res", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    chk("ld_b_fwd_res", ms_fwd_res, 32'hFFFF_FF80);
    chk("ld_b_fwd_dest", 32'(ms_fwd_dest), 32'd3);
    chk("ld_b_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ld_b_pc", ms_to_ws_bus[31:0], 32'h0000_0100);

    issue(mk(LD_HU, 1'b1, 1'b1, 5'd4, 32'h1000_0002, 32'h0000_0104));
    data_sram_rdata = 32'h8001_7FFF; #1;
    chk("ld_hu_hi", ms_to_ws_bus[63:32], 32'h0000_8001);
    issue(mk(LD_H, 1'b1, 1'b1, 5'd4, 32'h1000_0002, 32'h0000_0108));
    #1;
    chk("ld_h_hi", ms_to_ws_bus[63:32], 32'hFFFF_8001);
    issue(mk(LD_HU, 1'b1, 1'b1, 5'd4, 32'h1000_0000, 32'h0000_010C));
    #1;
    chk("ld_hu_lo", ms_to_ws_bus[63:32], 32'h0000_7FFF);
    issue(mk(LD_BU, 1'b1, 1'b1, 5'd6, 32'h0000_0001, 32'h0000_0110));
    data_sram_rdata = 32'h80FF_1234; #1;
    chk("ld_bu_b1", ms_to_ws_bus[63:32], 32'h0000_0012);
    issue(mk(LD_NONE, 1'b1, 1'b1, 5'd7, 32'h0000_2001, 32'h0000_0114));
    data_sram_rdata = 32'hCAFE_F00D; #1;
    chk("ld_default_w", ms_to_ws_bus[63:32], 32'hCAFE_F00D);

    issue(mk(LD_W, 1'b1, 1'b1, 5'd8, 32'h0000_3000, 32'h0000_0118));
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h1111_1111; #1;
    chk("stall_c1", ms_to_ws_bus[63:32], 32'h1111_1111);
    chk("stall_allowin", 32'(ms_allowin), 32'd0);
    tick();
    data_sram_rdata = 32'hDEAD_BEEF; #1;
    chk("stall_c2", ms_to_ws_bus[63:32], 32'h1111_1111);
    chk("stall_fwd_c2", ms_fwd_res, 32'h1111_1111);
    tick();
    chk("stall_c3", ms_to_ws_bus[63:32], 32'h1111_1111);
    chk("stall_valid_c3", 32'(ms_to_ws_valid), 32'd1);
    ws_allowin = 1'b1; #1;
    chk("stall_c4", ms_to_ws_bus[63:32], 32'h1111_1111);
    chk("stall_release_allowin", 32'(ms_allowin), 32'd1);
    issue(mk(LD_W, 1'b1, 1'b1, 5'd9, 32'h0000_3004, 32'h0000_011C));
    data_sram_rdata = 32'h5555_AAAA; #1;
    chk("after_hold_new_word", ms_to_ws_bus[63:32], 32'h5555_AAAA);

    issue(mk(LD_NONE, 1'b0, 1'b1, 5'd5, 32'h0000_0042, 32'h0000_0120));
    chk("alu_fwd_dest", 32'(ms_fwd_dest), 32'd5);
    chk("alu_fwd_res", ms_fwd_res, 32'h0000_0042);
    chk("alu_we_dest", 32'(ms_to_ws_bus[69:64]), 32'h25);
    issue(mk(LD_NONE, 1'b0, 1'b0, 5'd5, 32'h0000_0042, 32'h0000_0124));
    chk("nowe_fwd_dest", 32'(ms_fwd_dest), 32'd0);
    tick();
    chk("drain_valid", 32'(ms_to_ws_valid), 32'd0);

    issue(mk(LD_W, 1'b1, 1'b1, 5'd10, 32'h0000_4000, 32'h0000_0128));
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h7777_7777;
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("midrst_allowin", 32'(ms_allowin), 32'd1);
    chk("midrst_fwd_dest", 32'(ms_fwd_dest), 32'd0);
    reset = 1'b0;
    ws_allowin = 1'b1;
    issue(mk(LD_W, 1'b1, 1'b1, 5'd11, 32'h0000_4004, 32'h0000_012C));
    data_sram_rdata = 32'h0BAD_F00D; #1;
    chk("postrst_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("postrst_word", ms_to_ws_bus[63:32], 32'h0BAD_F00D);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
